// File: rtl/risc_pkg.sv
// Shared op-code definitions for the RISC execute pipeline.
package risc_pkg;

  localparam int unsigned OP_W = 3;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD   = 3'd0;
  localparam op_t OP_SUB   = 3'd1;
  localparam op_t OP_AND   = 3'd2;
  localparam op_t OP_OR    = 3'd3;
  localparam op_t OP_XOR   = 3'd4;
  localparam op_t OP_SLL   = 3'd5;
  localparam op_t OP_SRL   = 3'd6;
  localparam op_t OP_PASSB = 3'd7;

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU: eight ops with carry/borrow and signed-overflow status.
module risc_alu
  import risc_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  op_t           op,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          ovf
);

  localparam int unsigned SW = $clog2(DW);

  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [SW-1:0] shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SW-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DW-1:0];
        carry  = sum[DW];
        ovf    = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        // diff[DW] is the borrow out of the unsigned subtraction
        result = diff[DW-1:0];
        carry  = diff[DW];
        ovf    = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/risc_exec_pipe.sv
// Two-stage execute/store pipeline: ALU + range check into S1, memory access into S2,
// valid/ready handshake on both ends with an accumulator feeding operand A.
module risc_exec_pipe
  import risc_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          Asel,
  input  logic [2:0]    op,
  input  logic          st,
  input  logic [AW-1:0] add,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] mdata,
  output logic          zero,
  output logic          carry,
  output logic          ovf,
  output logic          err
);

  localparam int unsigned MAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [0:DEPTH-1];

  logic [DW-1:0]  acc;
  logic [DW-1:0]  opa;
  logic [DW-1:0]  alu_res;
  logic           alu_c;
  logic           alu_v;

  logic           s1_valid;
  logic [DW-1:0]  s1_res;
  logic           s1_c;
  logic           s1_v;
  logic [MAW-1:0] s1_idx;
  logic           s1_st;
  logic           s1_err;

  logic           s2_en;
  logic           s1_en;
  logic           accept;
  logic           xfer;
  logic [DW-1:0]  s2_data;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;
  assign accept   = in_valid && s1_en;
  assign xfer     = s1_valid && s2_en;

  // acc is written on the accept edge, so a chained request one cycle later already sees it
  assign opa = Asel ? acc : A;

  risc_alu #(.DW(DW)) u_alu (
    .a      (opa),
    .b      (B),
    .op     (op),
    .result (alu_res),
    .carry  (alu_c),
    .ovf    (alu_v)
  );

  always_comb begin
    s2_data = '0;
    if (!s1_err) s2_data = s1_st ? s1_res : mem[s1_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      s1_valid  <= 1'b0;
      s1_res    <= '0;
      s1_c      <= 1'b0;
      s1_v      <= 1'b0;
      s1_idx    <= '0;
      s1_st     <= 1'b0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      mdata     <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept && st) acc <= alu_res;
      if (s1_en) s1_valid <= in_valid;
      if (accept) begin
        s1_res <= alu_res;
        s1_c   <= alu_c;
        s1_v   <= alu_v;
        s1_idx <= add[MAW-1:0];
        s1_st  <= st;
        s1_err <= ({1'b0, add} >= DEPTH_W);
      end
      if (s2_en) out_valid <= s1_valid;
      if (xfer) begin
        mdata <= s2_data;
        zero  <= !s1_err && (s2_data == '0);
        carry <= s1_st && !s1_err && s1_c;
        ovf   <= s1_st && !s1_err && s1_v;
        err   <= s1_err;
      end
    end
  end

  // Writes happen only on the S1->S2 transfer, keeping memory order equal to request order
  always_ff @(posedge clk) begin
    if (rst && xfer && s1_st && !s1_err) mem[s1_idx] <= s1_res;
  end

endmodule

// File: tb/tb_risc_exec_pipe.sv
// Self-checking bench for risc_exec_pipe: directed scenarios plus randomized traffic
// scored against an in-order request/response model.
module tb_risc_exec_pipe;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] A = '0;
  logic [DW-1:0] B = '0;
  logic          Asel = 1'b0;
  logic [2:0]    op = '0;
  logic          st = 1'b0;
  logic [AW-1:0] add = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] mdata;
  logic          zero, carry, ovf, err;

  risc_exec_pipe #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Asel      (Asel),
    .op        (op),
    .st        (st),
    .add       (add),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mdata     (mdata),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        z;
    logic        c;
    logic        v;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [31:0] got[$];
  logic [31:0] mmem [0:DEPTH-1];
  logic [31:0] macc = '0;
  exp_t        last = '0;
  int          checks = 0;
  int          errors = 0;
  int          n_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic ovf32(input longint r);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Reference: compute the expected response from the request as it is accepted.
  function automatic void model_accept();
    exp_t            e;
    logic [31:0]     a, r;
    logic            c, v;
    longint          sa, sb;
    longint unsigned s;
    n_acc++;
    e = '0;
    if (st) begin
      a  = Asel ? macc : A;
      c  = 1'b0;
      v  = 1'b0;
      sa = $signed(a);
      sb = $signed(B);
      case (op)
        3'd0: begin s = 64'(a) + 64'(B); r = s[31:0]; c = (s >= 64'h1_0000_0000); v = ovf32(sa + sb); end
        3'd1: begin r = a - B; c = (a < B); v = ovf32(sa - sb); end
        3'd2: r = a & B;
        3'd3: r = a | B;
        3'd4: r = a ^ B;
        3'd5: r = a << (B % 32);
        3'd6: r = a >> (B % 32);
        default: r = B;
      endcase
      macc = r;
      if (add < DEPTH) begin
        mmem[add] = r;
        e.d = r; e.z = (r == 0); e.c = c; e.v = v;
      end else e.e = 1'b1;
    end else if (add < DEPTH) begin
      e.d = mmem[add];
      e.z = (e.d == 0);
    end else e.e = 1'b1;
    q.push_back(e);
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      check("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      if (out_valid && out_ready) begin
        check("out_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("mdata", 64'(mdata), 64'(e.d));
          check("flags", 64'({zero, carry, ovf, err}), 64'({e.z, e.c, e.v, e.e}));
          got.push_back(mdata);
          last = {mdata, zero, carry, ovf, err};
        end
      end
      if (in_valid && in_ready) model_accept();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic as, input logic [15:0] ad);
    int start;
    st = s; op = o; A = a; B = b; Asel = as; add = ad;
    in_valid = 1'b1;
    start = n_acc;
    for (int i = 0; i < 50 && n_acc == start; i++) tick();
    in_valid = 1'b0;
    if (n_acc == start) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    check("drain_empty", 64'(q.size()), 64'd0);
    check("drain_idle", 64'(out_valid), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 40));
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] prev5, prev7;
  int          r;

  initial begin
    // Reset held with a live store request on the inputs
    in_valid = 1'b1; st = 1'b1; op = 3'd7; B = 32'h55; add = 16'd4;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mdata", 64'(mdata), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_flags", 64'({zero, carry, ovf, err}), 64'd0);
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    for (int a = 0; a < 16; a++) send(1'b1, 3'd7, 32'd0, $urandom, 1'b0, 16'(a));
    send(1'b1, 3'd7, 32'd0, $urandom, 1'b0, 16'd255);
    drain();

    // Store then load, with first-result latency
    send(1'b1, 3'd0, 32'd12, 32'd14, 1'b0, 16'd3);
    check("lat_n", 64'(out_valid), 64'd0);
    tick();
    check("lat_n1_valid", 64'(out_valid), 64'd1);
    check("lat_n1_mdata", 64'(mdata), 64'd26);
    check("lat_n1_zero", 64'(zero), 64'd0);
    send(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd3);
    drain();
    check("load_back", 64'(last.d), 64'd26);

    // Accumulator chain
    got.delete();
    send(1'b1, 3'd0, 32'd10, 32'd14, 1'b0, 16'd0);
    send(1'b1, 3'd0, 32'd0,  32'd14, 1'b1, 16'd1);
    send(1'b1, 3'd1, 32'd0,  32'd38, 1'b1, 16'd2);
    drain();
    check("chain_n", 64'(got.size()), 64'd3);
    check("chain_0", 64'(got[0]), 64'd24);
    check("chain_1", 64'(got[1]), 64'd38);
    check("chain_2", 64'(got[2]), 64'd0);
    check("chain_zero", 64'(last.z), 64'd1);

    // Flags
    send(1'b1, 3'd1, 32'd12, 32'd14, 1'b0, 16'd8);
    drain();
    check("sub_mdata", 64'(last.d), 64'hFFFF_FFFE);
    check("sub_borrow", 64'(last.c), 64'd1);
    send(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 16'd9);
    drain();
    check("add_ovf", 64'(last.v), 64'd1);
    check("add_ovf_carry", 64'(last.c), 64'd0);
    send(1'b1, 3'd5, 32'd1, 32'd35, 1'b0, 16'd10);
    drain();
    check("sll_mdata", 64'(last.d), 64'd8);

    // Backpressure
    got.delete();
    out_ready = 1'b0;
    send(1'b1, 3'd0, 32'd15, 32'd14, 1'b0, 16'd11);
    send(1'b1, 3'd0, 32'd17, 32'd14, 1'b0, 16'd12);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    st = 1'b1; op = 3'd0; A = 32'd12; B = 32'd14; Asel = 1'b0; add = 16'd13; in_valid = 1'b1;
    repeat (3) begin
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_mdata", 64'(mdata), 64'd29);
    end
    out_ready = 1'b1;
    send(1'b1, 3'd0, 32'd12, 32'd14, 1'b0, 16'd13);
    drain();
    check("bp_n", 64'(got.size()), 64'd3);
    check("bp_0", 64'(got[0]), 64'd29);
    check("bp_1", 64'(got[1]), 64'd31);
    check("bp_2", 64'(got[2]), 64'd26);

    // Out-of-range store still updates acc
    send(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 16'd300);
    drain();
    check("range_err", 64'(last.e), 64'd1);
    check("range_mdata", 64'(last.d), 64'd0);
    check("range_flags", 64'({last.z, last.c, last.v}), 64'd0);
    send(1'b1, 3'd0, 32'd0, 32'd1, 1'b1, 16'd14);
    drain();
    check("range_acc", 64'(last.d), 64'd8);

    // Reset while a store is in flight, and requests offered during reset
    prev5 = mmem[5];
    prev7 = mmem[7];
    send(1'b1, 3'd7, 32'd0, 32'hAA, 1'b0, 16'd5);
    check("mid_pre_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    mmem[5] = prev5;
    macc = '0;
    st = 1'b1; op = 3'd7; B = 32'hDEAD; add = 16'd7; Asel = 1'b0; in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    send(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd5);
    send(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd7);
    send(1'b1, 3'd0, 32'd0, 32'd0, 1'b1, 16'd15);
    drain();
    check("mid_n", 64'(got.size()), 64'd3);
    check("mid_load5", 64'(got[0]), 64'(prev5));
    check("mid_load7", 64'(got[1]), 64'(prev7));
    check("mid_acc", 64'(got[2]), 64'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      st   = ($urandom_range(0, 9) < 7);
      op   = 3'($urandom_range(0, 7));
      A    = rnd_val();
      B    = rnd_val();
      Asel = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 19);
      if (r < 17)       add = 16'($urandom_range(0, 15));
      else if (r == 17) add = 16'd255;
      else if (r == 18) add = 16'd256;
      else              add = 16'($urandom_range(256, 65535));
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_exec_pipe.md
# risc_exec_pipe

Parametrised two-stage execute/store pipeline for the RISC datapath. Computes a selectable ALU operation on two operands, one optionally taken from an internal accumulator, and writes the result to an on-chip data memory. It returns the stored or loaded word on `mdata` through a valid/ready handshake. It replaces the fixed 32-bit single-op execute path and adds op select, load mode, status flags, range checking and backpressure.

## Interface
Parameters:
- `DW`, 32: data width; must be at least 8.
- `AW`, 16: width of the address bus `add`.
- `DEPTH`, 256: data-memory words; DEPTH ≤ 2^AW.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: request accepted on an edge where `in_valid` and `in_ready` are both 1.
- `A`  in  DW: operand A.
- `B`  in  DW: operand B.
- `Asel`  in  1: operand-A source. 0 selects port `A`; 1 selects the accumulator.
- `op`  in  3: ALU op code, see Operation.
- `st`  in  1: 1 means compute and store at `add`; 0 means load only (`op`, `A`, `B` and `Asel` are ignored).
- `add`  in  AW: word address.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `mdata`  out  DW: stored result or loaded word.
- `zero`, `carry`, `ovf`, `err`  out  1 each: status flags, qualified by `out_valid`.

## Operation
- Op codes:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: a << b[$clog2(DW)-1:0].
  - 6 SRL: logical right shift, same shift amount as SLL.
  - 7 PASSB: result = b.
- All arithmetic is modulo 2^DW.
- `carry`:
  - ADD: carry-out.
  - SUB: borrow, i.e. 1 when a < b unsigned.
  - All other ops: 0.
- `ovf`: signed overflow for ADD/SUB only, otherwise 0.
- `zero`: 1 when `mdata` == 0. This applies to loads too; loads force `carry` and `ovf` to 0.
- Accumulator `acc`, DW bits:
  - Loaded with the ALU result when a store request is accepted.
  - Not changed by loads.
  - With `Asel`=1, operand A is the result of the most recently accepted store, including one accepted on the immediately preceding edge. Back-to-back chaining needs no bubble.
- Stage S1, on accept:
  - Registers the ALU result and flags, `add`, `st`, and range status.
  - Range status: `err` = (`add` ≥ DEPTH).
- Stage S2, on S1→S2 transfer:
  - Store with `err`=0: mem[add] ← result; `mdata` ← result.
  - Load with `err`=0: `mdata` ← mem[add], synchronous read.
  - `err`=1: no memory access; `mdata` ← 0; `zero`, `carry` and `ovf` ← 0.
  - The accumulator is still updated for an out-of-range store.
- A load following a store to the same address always returns the stored value, since memory accesses occur in S2 in program order.
- Memory contents are not reset.

## Timing
- Handshake enables:
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - `in_ready` = s1_en, a combinational function of state and `out_ready`.
- Latency: a request accepted at edge N presents `out_valid`/`mdata` after edge N+1, provided `out_ready` was 1.
- Throughput: one request per cycle.
- While `out_valid`=1 and `out_ready`=0, `mdata` and all flags hold stable.
  - At most two requests are held in flight.
  - `in_ready` falls once S1 is also occupied.
- A memory write occurs only on an S1→S2 transfer, so each store writes exactly once.
- Reset (`rst`=0), asynchronous, values:
  - `out_valid`, s1_valid, `mdata`, `acc`, `zero`, `carry`, `ovf`, `err`: 0.
  - `in_ready`: 1.
- Reset mid-operation discards in-flight requests; no memory write occurs while `rst`=0.
- Reset deassertion is synchronised externally.

## Structure
- Package `risc_pkg`: op-code localparams (OP_ADD…OP_PASSB) and the op_t width.
- Sub-module `risc_alu`: purely combinational. Inputs DW-bit a, b and op; outputs result, carry and ovf. It is instantiated once, in front of S1.
- The data memory is an inferred `reg [DW-1:0] mem [0:DEPTH-1]` inside `risc_exec_pipe`, with synchronous write and synchronous read.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `mdata`=0, `in_ready`=1; no store occurs.
- **Store then load:** ADD A=12 B=14 add=3 `st`=1 → `mdata`=26 two edges later, `zero`=0. Then a load at add=3 → `mdata`=26.
- **Accumulator chain:** back-to-back requests, in order:
  - ADD A=10 B=14 → `mdata`=24.
  - `Asel`=1 ADD B=14 → `mdata`=38.
  - `Asel`=1 SUB B=38 → `mdata`=0, `zero`=1.
- **Flags:**
  - SUB 12−14 → `mdata`=0xFFFFFFFE, `carry`=1.
  - ADD 0x7FFFFFFF+1 → `ovf`=1.
  - SLL 1 by B=35 → `mdata`=8, since only B[4:0]=3 is used.
- **Backpressure:** `out_ready`=0 while issuing ADD results 15+14, 17+14 and 12+14 back-to-back.
  - `in_ready` goes 0 after two accepts.
  - `mdata` holds 29.
  - Raising `out_ready` yields 29, then 31, then 26, with no loss or duplication.
- **Range and mid-op reset:**
  - Store at add=300 with DEPTH=256 → `err`=1, `mdata`=0, `acc` updated.
  - Store 0xAA at add=5, then assert `rst` before out_valid → after reset, a load at add=5 returns the prior content, not 0xAA.
